// File: rtl/reg_file_sb.sv
// Register file with zero-on-start clear sweep, optional write-to-read bypass and
// a per-register busy scoreboard for outstanding results.
module reg_file_sb #(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_reg,
  input  logic [AW-1:0]   target_reg,
  input  logic [XLEN-1:0] write_rd_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_rs1_data,
  output logic [XLEN-1:0] read_rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            ready,
  output logic            fsm_state
);

  // Handshake: none. Every input is sampled on each rising edge; a write or issue
  // takes effect exactly on the edge where write_reg / issue_valid is high in RUN.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [DEPTH-1:0] ONE_HOT0 = DEPTH'(1);

  state_t            state, state_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic              sweep_we;
  logic              run;
  logic              wr_en;
  logic [XLEN-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  set_mask, clr_mask;
  logic              hit1, hit2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sweep_we  = 1'b0;
    case (state)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        idx_nxt  = idx + AW'(1);
        if (idx == LAST_IDX) state_nxt = ST_RUN;
      end
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  assign run       = (state == ST_RUN);
  assign ready     = run;
  assign fsm_state = state;
  assign wr_en     = run && write_reg && (target_reg != '0);

  // Storage has no reset: contents only become zero through the sweep.
  always_ff @(posedge clk) begin
    if (sweep_we)   regs[idx]        <= '0;
    else if (wr_en) regs[target_reg] <= write_rd_data;
  end

  assign clr_mask = write_reg ? (ONE_HOT0 << target_reg) : '0;
  assign set_mask = (issue_valid && (issue_rd != '0)) ? (ONE_HOT0 << issue_rd) : '0;

  // Set is applied after clear so a same-cycle issue of the written register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      busy <= '0;
    else if (!run) busy <= '0;
    else           busy <= (busy & ~clr_mask) | set_mask;
  end

  assign hit1 = run && (BYPASS != 0) && write_reg && (target_reg == rs1) && (rs1 != '0);
  assign hit2 = run && (BYPASS != 0) && write_reg && (target_reg == rs2) && (rs2 != '0);

  always_comb begin
    read_rs1_data = '0;
    rs1_busy      = 1'b0;
    if (run && (rs1 != '0)) begin
      read_rs1_data = hit1 ? write_rd_data : regs[rs1];
      rs1_busy      = busy[rs1] & ~hit1;
    end
  end

  always_comb begin
    read_rs2_data = '0;
    rs2_busy      = 1'b0;
    if (run && (rs2 != '0)) begin
      read_rs2_data = hit2 ? write_rd_data : regs[rs2];
      rs2_busy      = busy[rs2] & ~hit2;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default, no-bypass and 64x16 instances,
// with a behavioural model of the default instance feeding an expected queue.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // default instance (XLEN 32, DEPTH 32, bypass on)
  logic        wr_a, iv_a;
  logic [4:0]  tgt_a, rs1_a, rs2_a, ird_a;
  logic [31:0] wd_a, rd1_a, rd2_a;
  logic        b1_a, b2_a, rdy_a, st_a;

  // bypass off
  logic        wr_b, iv_b;
  logic [4:0]  tgt_b, rs1_b, rs2_b, ird_b;
  logic [31:0] wd_b, rd1_b, rd2_b;
  logic        b1_b, b2_b, rdy_b, st_b;

  // XLEN 64, DEPTH 16
  logic        wr_c, iv_c;
  logic [3:0]  tgt_c, rs1_c, rs2_c, ird_c;
  logic [63:0] wd_c, rd1_c, rd2_c;
  logic        b1_c, b2_c, rdy_c, st_c;

  reg_file_sb dut_a (
    .clk(clk), .rst(rst), .write_reg(wr_a), .target_reg(tgt_a), .write_rd_data(wd_a),
    .rs1(rs1_a), .rs2(rs2_a), .read_rs1_data(rd1_a), .read_rs2_data(rd2_a),
    .issue_valid(iv_a), .issue_rd(ird_a), .rs1_busy(b1_a), .rs2_busy(b2_a),
    .ready(rdy_a), .fsm_state(st_a)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .write_reg(wr_b), .target_reg(tgt_b), .write_rd_data(wd_b),
    .rs1(rs1_b), .rs2(rs2_b), .read_rs1_data(rd1_b), .read_rs2_data(rd2_b),
    .issue_valid(iv_b), .issue_rd(ird_b), .rs1_busy(b1_b), .rs2_busy(b2_b),
    .ready(rdy_b), .fsm_state(st_b)
  );

  reg_file_sb #(.XLEN(64), .DEPTH(16)) dut_c (
    .clk(clk), .rst(rst), .write_reg(wr_c), .target_reg(tgt_c), .write_rd_data(wd_c),
    .rs1(rs1_c), .rs2(rs2_c), .read_rs1_data(rd1_c), .read_rs2_data(rd2_c),
    .issue_valid(iv_c), .issue_rd(ird_c), .rs1_busy(b1_c), .rs2_busy(b2_c),
    .ready(rdy_c), .fsm_state(st_c)
  );

  // ---------------- model of dut_a ----------------
  logic [31:0] mdl [32];
  logic [31:0] mbusy;
  int          sweep_left;

  function automatic logic m_run();
    return (rst === 1'b1) && (sweep_left == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (!m_run() || rs == 5'd0) return 32'd0;
    if (wr_a && tgt_a == rs) return wd_a;
    return mdl[rs];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
    if (!m_run() || rs == 5'd0) return 1'b0;
    if (wr_a && tgt_a == rs) return 1'b0;
    return mbusy[rs];
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [63:0] got);
    logic [63:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check_eq(tag, got, e);
  endtask

  task automatic check_a();
    exp_q.push_back(64'(m_run()));
    exp_q.push_back(64'(exp_rd(rs1_a)));
    exp_q.push_back(64'(exp_rd(rs2_a)));
    exp_q.push_back(64'(exp_busy(rs1_a)));
    exp_q.push_back(64'(exp_busy(rs2_a)));
    #1;
    pop_check("a_ready", 64'(rdy_a));
    pop_check("a_rd1",   64'(rd1_a));
    pop_check("a_rd2",   64'(rd2_a));
    pop_check("a_busy1", 64'(b1_a));
    pop_check("a_busy2", 64'(b2_a));
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    if (rst === 1'b1) begin
      if (sweep_left > 0) sweep_left--;
      else begin
        if (wr_a && tgt_a != 5'd0) mdl[tgt_a] = wd_a;
        if (wr_a) mbusy[tgt_a] = 1'b0;
        if (iv_a && ird_a != 5'd0) mbusy[ird_a] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_a = 1'b0; iv_a = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mbusy = '0;
    sweep_left = 32;
    #1;
    check_a();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic read_all_a();
    idle_a();
    for (int r = 0; r < 32; r++) begin
      rs1_a = 5'(r); rs2_a = 5'(31 - r);
      check_a();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    wr_a = 0; iv_a = 0; tgt_a = 0; rs1_a = 0; rs2_a = 0; ird_a = 0; wd_a = 0;
    wr_b = 0; iv_b = 0; tgt_b = 0; rs1_b = 0; rs2_b = 0; ird_b = 0; wd_b = 0;
    wr_c = 0; iv_c = 0; tgt_c = 0; rs1_c = 0; rs2_c = 0; ird_c = 0; wd_c = 0;
    @(posedge clk);
    #1;

    // reset, then sweep with writes/issues that must be ignored
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      wr_a = (i < 32); tgt_a = 5'($urandom_range(1, 31)); wd_a = $urandom;
      iv_a = (i < 32); ird_a = 5'($urandom_range(1, 31));
      rs1_a = 5'($urandom_range(0, 31)); rs2_a = 5'($urandom_range(0, 31));
      if (i == 32) idle_a();
      check_a();
      if (i < 32) tick();
    end

    // preload every register, then reset and confirm the sweep zeroes them
    for (int r = 1; r < 32; r++) begin
      wr_a = 1'b1; tgt_a = 5'(r); wd_a = $urandom;
      rs1_a = 5'(r); rs2_a = 5'(r - 1);
      check_a();
      tick();
    end
    read_all_a();
    do_reset();
    for (int i = 0; i < 32; i++) tick();
    read_all_a();

    // same-cycle bypass
    wr_a = 1'b1; tgt_a = 5'd5; wd_a = 32'hDEADBEEF; rs1_a = 5'd5; rs2_a = 5'd6;
    check_a();
    tick();
    idle_a();
    check_a();

    // register 0: write discarded, issue ignored
    wr_a = 1'b1; tgt_a = 5'd0; wd_a = 32'h12345678; iv_a = 1'b1; ird_a = 5'd0;
    rs1_a = 5'd0; rs2_a = 5'd0;
    check_a();
    tick();
    idle_a();
    check_a();

    // busy set, set-wins-over-clear, later clear
    iv_a = 1'b1; ird_a = 5'd7; rs1_a = 5'd3; rs2_a = 5'd7;
    check_a();
    tick();
    idle_a();
    check_a();
    wr_a = 1'b1; tgt_a = 5'd7; wd_a = 32'hA5A5_0007; iv_a = 1'b1; ird_a = 5'd7;
    check_a();
    tick();
    idle_a();
    check_a();
    wr_a = 1'b1; tgt_a = 5'd7; wd_a = 32'h0000_7777;
    tick();
    idle_a();
    rs1_a = 5'd7;
    check_a();

    // reset at sweep index 10, writes during the restarted sweep are ignored
    iv_a = 1'b1; ird_a = 5'd9;
    tick();
    idle_a();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wr_a = 1'b1; tgt_a = 5'd3; wd_a = $urandom;
      tick();
    end
    read_all_a();

    // random traffic, including rs1 == rs2
    for (int i = 0; i < 300; i++) begin
      wr_a  = 1'($urandom_range(0, 1)); tgt_a = 5'($urandom_range(0, 31)); wd_a = $urandom;
      iv_a  = 1'($urandom_range(0, 1)); ird_a = 5'($urandom_range(0, 31));
      rs1_a = 5'($urandom_range(0, 31));
      rs2_a = ($urandom_range(0, 3) == 0) ? rs1_a : 5'($urandom_range(0, 31));
      check_a();
      tick();
    end
    idle_a();

    // 16-entry sweep length
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      exp_q.push_back(64'(i >= 16));
      #1;
      pop_check("c_ready", 64'(rdy_c));
      tick();
    end
    for (int i = 17; i < 32; i++) tick();

    // no-bypass instance: old value in the write cycle, new value after
    wr_b = 1'b1; tgt_b = 5'd5; wd_b = 32'hDEADBEEF; rs1_b = 5'd5;
    exp_q.push_back(64'd0);
    #1;
    pop_check("b_rd1_same", 64'(rd1_b));
    tick();
    wr_b = 1'b0;
    exp_q.push_back(64'hDEADBEEF);
    #1;
    pop_check("b_rd1_next", 64'(rd1_b));
    iv_b = 1'b1; ird_b = 5'd9;
    tick();
    iv_b = 1'b0; wr_b = 1'b1; tgt_b = 5'd9; wd_b = 32'h99; rs1_b = 5'd9;
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    #1;
    pop_check("b_busy_same", 64'(b1_b));
    pop_check("b_rd_same",   64'(rd1_b));
    tick();
    wr_b = 1'b0;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h99);
    #1;
    pop_check("b_busy_next", 64'(b1_b));
    pop_check("b_rd_next",   64'(rd1_b));

    // 64-bit instance: all-ones to the top register
    wr_c = 1'b1; tgt_c = 4'd15; wd_c = 64'hFFFF_FFFF_FFFF_FFFF; rs1_c = 4'd15; rs2_c = 4'd14;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'd0);
    #1;
    pop_check("c_rd1_byp", rd1_c);
    pop_check("c_rd2_old", rd2_c);
    tick();
    wr_c = 1'b0; rs1_c = 4'd0; rs2_c = 4'd15;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    pop_check("c_rd1_zero", rd1_c);
    pop_check("c_rd2_ones", rd2_c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
